// File: rtl/br_resolve.sv
// Branch resolver with a 2-bit saturating branch history table.
// The execute stage resolves a conditional branch from the comparator flags.
// The fetch stage reads the BHT to get a prediction.
// Optional statistics counters are built only when BR_STATS_EN is defined.
module br_resolve #(
   parameter  int BHT_ENTRIES = 16,
   localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_if_pc,
   output logic        o_pred_taken,
   input  logic        i_ex_valid,
   input  logic        i_ex_is_br,
   input  logic [2:0]  i_ex_funct3,
   input  logic [31:0] i_ex_pc,
   input  logic        i_ex_pred_taken,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_br_un,
   output logic        o_taken,
   output logic        o_mispredict,
   output logic        o_illegal_br,
   output logic [31:0] o_br_count,
   output logic [31:0] o_mispred_count
);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx, ex_idx;
   logic             br_act, cond, rsvd, upd;
   logic             unused_pc;

   // Byte offset and the upper PC bits alias; they are dropped on purpose.
   assign if_idx    = i_if_pc[IDX_W+1:2];
   assign ex_idx    = i_ex_pc[IDX_W+1:2];
   assign unused_pc = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0],
                        i_ex_pc[31:IDX_W+2], i_ex_pc[1:0]};

   assign br_act  = i_ex_valid & i_ex_is_br;
   assign o_br_un = (i_ex_funct3 == 3'b110) | (i_ex_funct3 == 3'b111);

   // Decode the raw taken condition for each funct3. This logic ignores valid.
   always_comb begin
      cond = 1'b0;
      rsvd = 1'b0;
      case (i_ex_funct3)
         3'b000:         cond = i_br_equal;
         3'b001:         cond = ~i_br_equal;
         3'b100, 3'b110: cond = i_br_less;
         3'b101, 3'b111: cond = ~i_br_less;
         default:        rsvd = 1'b1;
      endcase
   end

   assign o_illegal_br = br_act & rsvd;
   assign o_taken      = br_act & ~rsvd & cond;
   assign o_mispredict = br_act & ~rsvd & (o_taken != i_ex_pred_taken);
   assign upd          = br_act & ~rsvd;

   // The prediction reads the pre-update entry. An update in the same cycle shows up one cycle later.
   assign o_pred_taken = bht[if_idx][1];

   // BHT: reset to weakly not-taken. A resolved branch moves its entry one step and saturates.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (upd) begin
         if (o_taken) begin
            if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
         end else begin
            if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
         end
      end
   end

`ifdef BR_STATS_EN
   logic [31:0] br_cnt, mis_cnt;

   // Free-running statistics counters. They wrap on overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else begin
         if (upd)          br_cnt  <= br_cnt + 32'd1;
         if (o_mispredict) mis_cnt <= mis_cnt + 32'd1;
      end
   end

   assign o_br_count      = br_cnt;
   assign o_mispred_count = mis_cnt;
`else
   assign o_br_count      = 32'h0;
   assign o_mispred_count = 32'h0;
`endif

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Consumer side of the branch comparator: takes comparator flags plus decoded branch funct3 at execute and resolves the branch as taken or not-taken.
- Drives the comparator's signed/unsigned select (o_br_un) back to it.
- Keeps a 2-bit saturating branch history table (BHT), read at fetch for prediction and updated at execute. Flags mispredictions so the PC mux can redirect.

Parameters:
- BHT_ENTRIES, 16, number of BHT entries; power of two, 2..256.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, do not override.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_if_pc  input  32  fetch-stage PC used for prediction lookup.
- o_pred_taken  output  1  prediction for i_if_pc: MSB of BHT[i_if_pc[IDX_W+1:2]].
- i_ex_valid  input  1  execute-stage instruction valid (low on stall or bubble).
- i_ex_is_br  input  1  execute instruction is a conditional branch.
- i_ex_funct3  input  3  branch funct3.
- i_ex_pc  input  32  PC of the execute-stage branch.
- i_ex_pred_taken  input  1  prediction carried down the pipe with that branch.
- i_br_less  input  1  comparator rs1<rs2 flag.
- i_br_equal  input  1  comparator rs1==rs2 flag.
- o_br_un  output  1  to comparator: 1 unsigned, 0 signed.
- o_taken  output  1  resolved branch outcome.
- o_mispredict  output  1  resolved outcome differs from i_ex_pred_taken.
- o_illegal_br  output  1  branch with reserved funct3.
- o_br_count  output  32  resolved-branch counter (optional feature).
- o_mispred_count  output  32  misprediction counter (optional feature).

Behaviour:
- o_br_un is combinational: 1 when i_ex_funct3 is 110 or 111, else 0. It does not depend on valid.
- Resolution is combinational, valid only when br_act = i_ex_valid & i_ex_is_br. Taken condition by funct3:
  - 000 BEQ: taken = equal.
  - 001 BNE: taken = !equal.
  - 100 BLT / 110 BLTU: taken = less.
  - 101 BGE / 111 BGEU: taken = !less.
  - 010 / 011: not taken, and o_illegal_br = 1.
- When br_act = 0: o_taken, o_mispredict and o_illegal_br are 0.
- o_mispredict = br_act & !illegal & (o_taken != i_ex_pred_taken).
- Illegal branch: o_mispredict = 0.
- BHT storage and reset:
  - BHT_ENTRIES x 2-bit registers.
  - Asynchronous reset sets every entry to 2'b01 (weakly not-taken).
  - o_pred_taken reads combinationally. During reset all entries read 01, so o_pred_taken = 0.
- BHT update, on the rising clock edge when br_act & !illegal:
  - Entry indexed by i_ex_pc[IDX_W+1:2].
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
  - Exactly one entry changes per cycle; no update otherwise.
- Read/write collision (same index, same cycle): o_pred_taken returns the pre-update value. The new value is visible the next cycle. No bypass.
- Stall (i_ex_valid = 0): no state change, even if the other inputs toggle.
- Reset asserted mid-operation: all entries and counters clear immediately, regardless of the clock. The first update occurs on the first edge after deassertion.
- PC bits [1:0] and bits above IDX_W+1 are ignored; aliasing between branches is permitted.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - o_br_count increments on each edge with br_act & !illegal.
  - o_mispred_count increments on each edge with o_mispredict = 1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both outputs tie to 32'h0 and no counter flops are built.

Test Plan:
- Reset, then i_if_pc = 0x40 -> o_pred_taken = 0. Hold i_rst_n low across 3 edges with br_act = 1 -> BHT unchanged (all 01), counters 0.
- i_ex_funct3 = 110, i_br_less = 1, br_act = 1, i_ex_pred_taken = 0 -> o_br_un = 1, o_taken = 1, o_mispredict = 1. Next cycle, i_if_pc = i_ex_pc = 0x40 -> o_pred_taken = 1 (entry 10).
- Four taken BEQs (equal = 1) at PC 0x80 -> entry saturates at 3. Then two not-taken -> entry 1, o_pred_taken = 0. A further taken -> 2, o_pred_taken = 1.
- i_ex_funct3 = 010 with equal = 1, less = 1 -> o_illegal_br = 1, o_taken = 0, o_mispredict = 0. BHT and counters unchanged.
- Same-cycle update to 0x80 and i_if_pc = 0x80 (entry 01 -> 10) -> o_pred_taken = 0 that cycle, 1 the next. i_ex_valid = 0 with branch inputs active -> no update.
- BR_STATS_EN defined: 5 legal branches with 2 mispredicts -> o_br_count = 5, o_mispred_count = 2. Force o_br_count to 0xFFFFFFFF, then one branch -> 0.
